// File: rtl/carry_chain_pipe_adder.sv
// carry_chain_pipe_adder: pipelined WIDTH-bit adder, one 4-bit ripple slice per stage.
// Stage 0 reads the input ports directly. Each later stage is a register set that holds
// the partial sum, the inter-slice carry and the operand bits that are still unused.
// The last slice writes the output registers, so a result appears SLICES cycles after
// it is accepted.
//
// Optional feature: define CARRY_CHAIN_OVF_EN to add the out_ovf port (signed overflow).
//
// Stream handshake: a transfer happens on a rising edge where valid && ready.
// The whole pipe moves only when the output register is empty or is being drained
// (advance = !out_valid || out_ready), and in_ready equals advance. in_ready never
// depends on in_valid. While advance is low every register holds its value.

module carry_chain_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;

  // Plain 4-bit ripple: generate and propagate terms per bit.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = c[4];
  end
endmodule

module carry_chain_pipe_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CARRY_CHAIN_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);
  localparam int SLICES = WIDTH / 4;
  // Number of inter-stage register sets (kept at least 1 so the arrays stay legal).
  localparam int MID    = (SLICES > 1) ? SLICES - 1 : 1;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("carry_chain_pipe_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  logic advance;

  // Inputs seen by each slice: ports for slice 0, stage registers after that.
  // Operand views are right-aligned: the slice always consumes bits [3:0].
  // The sum view fills from the top; after SLICES shifts the first nibble is at bit 0.
  logic             v_in [SLICES];
  logic             c_in [SLICES];
  logic [WIDTH-1:0] a_in [SLICES];
  logic [WIDTH-1:0] b_in [SLICES];
  logic [WIDTH-1:0] s_in [SLICES];

  // Slice results.
  logic [3:0]       nib  [SLICES];
  logic             co   [SLICES];

  // Next-state values produced behind each slice.
  logic             v_d  [SLICES];
  logic             c_d  [SLICES];
  logic [WIDTH-1:0] s_d  [SLICES];
  logic [WIDTH-1:0] a_d  [SLICES];
  logic [WIDTH-1:0] b_d  [SLICES];

  // Inter-stage registers; element k holds the result of slice k.
  logic             p_v_q [MID];
  logic             p_c_q [MID];
  logic [WIDTH-1:0] p_s_q [MID];
  logic [WIDTH-1:0] p_a_q [MID];
  logic [WIDTH-1:0] p_b_q [MID];

  // Output registers.
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign v_in[k] = in_valid;
      assign c_in[k] = in_cin;
      assign a_in[k] = in_a;
      assign b_in[k] = in_b;
      assign s_in[k] = '0;
    end else begin : g_later
      assign v_in[k] = p_v_q[k-1];
      assign c_in[k] = p_c_q[k-1];
      assign a_in[k] = p_a_q[k-1];
      assign b_in[k] = p_b_q[k-1];
      assign s_in[k] = p_s_q[k-1];
    end

    carry_chain_4bit u_slice (
      .a_i (a_in[k][3:0]),
      .b_i (b_in[k][3:0]),
      .c_i (c_in[k]),
      .s_o (nib[k]),
      .c_o (co[k])
    );
  end

  // Next stage state: valid and carry forward, new nibble enters the sum at the top,
  // consumed operand nibbles are shifted out.
  always_comb begin
    for (int k = 0; k < SLICES; k++) begin
      v_d[k] = v_in[k];
      c_d[k] = co[k];
      s_d[k] = (s_in[k] >> 4) | (WIDTH'(nib[k]) << (WIDTH - 4));
      a_d[k] = a_in[k] >> 4;
      b_d[k] = b_in[k] >> 4;
    end
  end

  // Inter-stage registers: cleared on reset, frozen while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MID; k++) begin
        p_v_q[k] <= 1'b0;
        p_c_q[k] <= 1'b0;
        p_s_q[k] <= '0;
        p_a_q[k] <= '0;
        p_b_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < SLICES - 1; k++) begin
        p_v_q[k] <= v_d[k];
        p_c_q[k] <= c_d[k];
        p_s_q[k] <= s_d[k];
        p_a_q[k] <= a_d[k];
        p_b_q[k] <= b_d[k];
      end
    end
  end

  // Output registers capture the last slice; a bubble clears out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= v_d[SLICES-1];
      out_sum_q   <= s_d[SLICES-1];
      out_cout_q  <= c_d[SLICES-1];
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

`ifdef CARRY_CHAIN_OVF_EN
  // Signed overflow uses the operand MSBs still held by the last stage.
  logic ovf_d;
  logic ovf_q;

  // Overflow when both operands agree in sign and the sum sign differs.
  always_comb begin
    ovf_d = (a_in[SLICES-1][3] == b_in[SLICES-1][3]) &&
            (nib[SLICES-1][3] != a_in[SLICES-1][3]);
  end

  // Overflow flag moves with the output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_chain_pipe_adder.sv
// Bench for carry_chain_pipe_adder: a WIDTH=16 instance with scoreboard, plus
// WIDTH=4 and WIDTH=32 instances exercised with short directed sequences.
module tb_carry_chain_pipe_adder;
  localparam int W  = 16;
  localparam int EW = W + 2;   // {ovf, cout, sum}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT W=16 ----------------
  logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [W-1:0] in_a, in_b, out_sum;
`ifdef CARRY_CHAIN_OVF_EN
  logic         out_ovf;
`endif

  carry_chain_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum),
`ifdef CARRY_CHAIN_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_cout(out_cout)
  );

  // ---------------- DUT W=4 ----------------
  logic       v4, r4, cin4, ov4, or4, co4;
  logic [3:0] a4, b4, s4;
`ifdef CARRY_CHAIN_OVF_EN
  logic       ovf4;
`endif

  carry_chain_pipe_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(r4),
    .in_a(a4), .in_b(b4), .in_cin(cin4),
    .out_valid(ov4), .out_ready(or4),
    .out_sum(s4),
`ifdef CARRY_CHAIN_OVF_EN
    .out_ovf(ovf4),
`endif
    .out_cout(co4)
  );

  // ---------------- DUT W=32 ----------------
  logic        v32, r32, cin32, ov32, or32, co32;
  logic [31:0] a32, b32, s32;
`ifdef CARRY_CHAIN_OVF_EN
  logic        ovf32;
`endif

  carry_chain_pipe_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .in_cin(cin32),
    .out_valid(ov32), .out_ready(or32),
    .out_sum(s32),
`ifdef CARRY_CHAIN_OVF_EN
    .out_ovf(ovf32),
`endif
    .out_cout(co32)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model for random stimulus.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  // ---------------- output monitor ----------------
  logic         stall_prev = 1'b0;
  logic [W-1:0] hold_sum   = '0;
  logic         hold_cout  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("sum", 32'(out_sum), 32'(exp_q[0][W-1:0]));
          check("cout", 32'(out_cout), 32'(exp_q[0][W]));
`ifdef CARRY_CHAIN_OVF_EN
          check("ovf", 32'(out_ovf), 32'(exp_q[0][W+1]));
`endif
          void'(exp_q.pop_front());
        end
      end
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_sum", 32'(out_sum), 32'(hold_sum));
        check("stall_cout", 32'(out_cout), 32'(hold_cout));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      stall_prev <= out_valid && !out_ready;
      hold_sum   <= out_sum;
      hold_cout  <= out_cout;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [EW-1:0] e, output int waits);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    check("send_accept", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid rises.
  task automatic measure_latency(input int expect_lat);
    int n;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", 32'(n), 32'(expect_lat));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_no_output", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      input logic [3:0] es, input logic ec);
    int n;
    a4 = a; b4 = b; cin4 = cin; v4 = 1'b1;
    @(negedge clk);
    check("w4_in_ready", 32'(r4), 32'd1);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    n = 1;
    @(negedge clk);
    while (!ov4 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("w4_latency", 32'(n), 32'd1);
    check("w4_sum", 32'(s4), 32'(es));
    check("w4_cout", 32'(co4), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [31:0] es, input logic ec);
    int n;
    a32 = a; b32 = b; cin32 = cin; v32 = 1'b1;
    @(negedge clk);
    check("w32_in_ready", 32'(r32), 32'd1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    n = 1;
    @(negedge clk);
    while (!ov32 && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("w32_latency", 32'(n), 32'd8);
    check("w32_sum", s32, es);
    check("w32_cout", 32'(co32), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    logic [W-1:0] ra, rb;
    logic         rc;

    //            a         b         cin   sum       cout  ovf
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9] = '{16'h8765, 16'h9ABC, 1'b0, 16'h2221, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; or4 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; or32 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
`ifdef CARRY_CHAIN_OVF_EN
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single add with latency
    send(vecs[0].a, vecs[0].b, vecs[0].cin, {vecs[0].ovf, vecs[0].cout, vecs[0].sum}, w);
    measure_latency(4);
    drain();

    // Directed table, back to back
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, w);
      check("table_no_wait", 32'(w), 32'd0);
    end
    drain();

    // 100-set stream, in_ready must stay high
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
      send(ra, rb, rc, model(ra, rb, rc), w);
      check("stream_no_wait", 32'(w), 32'd0);
    end
    drain();

    // Backpressure: out_ready low for 6 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(0, 1));
          send(ra, rb, rc, model(ra, rb, rc), w);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-flight: one result at the output, three more in the pipe
    for (int i = 0; i < 4; i++) begin
      send(vecs[6 + i].a, vecs[6 + i].b, vecs[6 + i].cin,
           {vecs[6 + i].ovf, vecs[6 + i].cout, vecs[6 + i].sum}, w);
    end
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_out_cout", 32'(out_cout), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002}, w);
    measure_latency(4);
    drain();

    // Other widths
    run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
    run4(4'h7, 4'h8, 1'b1, 4'h0, 1'b1);
    run4(4'h3, 4'h4, 1'b0, 4'h7, 1'b0);
    run32(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
    run32(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end
endmodule
